pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 133 +++++++++++++
 tb/tb_pattern_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Burst pattern generator: emits walking-one, walking-zero, count or PRBS words
// over a valid/ready stream, one burst per start request.
module pattern_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {M_WALK1, M_WALK0, M_COUNT, M_PRBS} mode_t;

    localparam logic [31:0]       PRBS_SEED = 32'h0000_0001;
    localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state;
    mode_t             mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [31:0]       lfsr;

    logic [31:0]       lfsr_shift;
    logic [31:0]       lfsr_next;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] seed_word;
    logic [LEN_W-1:0]  cnt_next;
    logic              xfer;

    assign xfer     = o_valid & i_ready;
    assign cnt_next = beat_cnt + 1'b1;

    // The feedback bit is taken from the register after the shift.
    assign lfsr_shift = {lfsr[30:0], 1'b0};
    assign lfsr_next  = {lfsr_shift[31:1],
                         lfsr_shift[31] ^ lfsr_shift[21] ^ lfsr_shift[1] ^ lfsr_shift[0]};

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        data_next = o_data;
        unique case (mode_q)
            M_WALK1, M_WALK0: data_next = {o_data[DATA_W-2:0], o_data[DATA_W-1]};
            M_COUNT:          data_next = o_data + DATA_ONE;
            M_PRBS:           data_next = lfsr_next[DATA_W-1:0];
            default:          data_next = o_data;
        endcase
    end

    always_comb begin
        seed_word = '0;
        unique case (mode_t'(i_mode))
            M_WALK1: seed_word = DATA_ONE;
            M_WALK0: seed_word = ~DATA_ONE;
            M_COUNT: seed_word = '0;
            M_PRBS:  seed_word = PRBS_SEED[DATA_W-1:0];
            default: seed_word = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            mode_q   <= M_WALK1;
            len_q    <= '0;
            beat_cnt <= '0;
            lfsr     <= PRBS_SEED;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            mode_q   <= mode_t'(i_mode);
                            len_q    <= i_len;
                            beat_cnt <= '0;
                            lfsr     <= PRBS_SEED;
                            o_data   <= seed_word;
                            o_valid  <= 1'b1;
                            o_last   <= (i_len == LEN_ONE);
                            o_busy   <= 1'b1;
                            state    <= S_RUN;
                        end else begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (o_last) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            // beat_cnt peaks at len_q-1, so a full-length burst never wraps it.
                            beat_cnt <= cnt_next;
                            o_data   <= data_next;
                            o_last   <= (cnt_next == len_q - 1'b1);
                            if (mode_q == M_PRBS) begin
                                lfsr <= lfsr_next;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: directed scenarios plus randomized bursts
// compared against a per-beat arithmetic model of each pattern.
module tb_pattern_gen;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [1:0]    i_mode;
    logic [LW-1:0] i_len;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    pattern_gen #(.DATA_W(DW), .LEN_W(LW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_mode  (i_mode),
        .i_len   (i_len),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    // PRBS rule: shift left, then bit0 = b31^b21^b1^b0 of the shifted word.
    function automatic logic [31:0] prbs_step(input logic [31:0] s0);
        logic [31:0] s;
        s    = s0 << 1;
        s[0] = s[31] ^ s[21] ^ s[1] ^ s[0];
        return s;
    endfunction

    // Expected word for beat k of a burst, straight from the pattern definitions.
    function automatic logic [DW-1:0] model_word(input logic [1:0] mode, input int k,
                                                 input logic [31:0] lf);
        logic [DW-1:0] w1;
        w1         = '0;
        w1[k % DW] = 1'b1;
        case (mode)
            2'd0:    return w1;
            2'd1:    return ~w1;
            2'd2:    return DW'(k);
            default: return lf[DW-1:0];
        endcase
    endfunction

    // ready_mode: 0 always ready, 1 pattern 1,0,0,1 repeating, 2 random ~60%.
    // disturb: scramble i_start/i_mode/i_len while the burst runs.
    task automatic run_burst(input logic [1:0] mode, input int len, input int ready_mode,
                             input bit disturb);
        int            k;
        int            cyc;
        int            budget;
        logic [31:0]   lf;
        logic [DW-1:0] exp_d;
        bit            r;
        @(negedge i_clk);
        i_start = 1'b1;
        i_mode  = mode;
        i_len   = len[LW-1:0];
        i_ready = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        k       = 0;
        cyc     = 0;
        lf      = 32'h1;
        budget  = len * 8 + 16;
        while (k < len && cyc < budget) begin
            exp_d = model_word(mode, k, lf);
            checks++;
            if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL valid_busy mode %0d beat %0d: valid=%b busy=%b, want 1 1",
                         mode, k, o_valid, o_busy);
            end
            checks++;
            if (o_data !== exp_d || o_last !== (k == len - 1)) begin
                errors++;
                $display("FAIL data mode %0d beat %0d: data=%h last=%b, want data=%h last=%b",
                         mode, k, o_data, o_last, exp_d, (k == len - 1));
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = ($urandom_range(0, 9) < 6);
            endcase
            i_ready = r;
            if (disturb) begin
                i_start = 1'($urandom_range(0, 1));
                i_mode  = 2'($urandom_range(0, 3));
                i_len   = LW'($urandom);
            end
            if (r) begin
                k++;
                if (mode == 2'd3) lf = prbs_step(lf);
            end
            cyc++;
            @(negedge i_clk);
        end
        i_start = 1'b0;
        i_ready = 1'b0;
        checks++;
        if (k < len) begin
            errors++;
            $display("FAIL burst_timeout mode %0d: %0d of %0d beats, want all", mode, k, len);
        end else if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse mode %0d len %0d: done=%b valid=%b busy=%b, want 1 0 0",
                     mode, len, o_done, o_valid, o_busy);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_width mode %0d: done=%b valid=%b, want 0 0", mode, o_done, o_valid);
        end
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_mode  = 2'd0;
        i_len   = '0;
        i_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_data, o_valid, o_last, o_busy, o_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h v=%b l=%b b=%b d=%b, want all 0",
                     o_data, o_valid, o_last, o_busy, o_done);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_walking_one();
        run_burst(2'd0, 34, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_burst(2'd2, 4, 1, 1'b0);
    endtask

    task automatic test_prbs();
        run_burst(2'd3, 3, 0, 1'b0);
        run_burst(2'd3, 50, 2, 1'b0);
    endtask

    task automatic test_zero_len();
        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_done: valid=%b done=%b, want 0 1", o_valid, o_done);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: valid=%b done=%b busy=%b, want 0 0 0",
                     o_valid, o_done, o_busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge i_clk);
        i_start = 1'b1;
        i_mode  = 2'd1;
        i_len   = LW'(10);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        checks++;
        if (o_data !== ~(32'h1 << 5) || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_beat5: data=%h valid=%b, want %h 1", o_data, o_valid,
                     ~(32'h1 << 5));
        end
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_data, o_valid, o_last, o_busy, o_done} !== '0) begin
            errors++;
            $display("FAIL async_reset: data=%h v=%b l=%b b=%b d=%b, want all 0",
                     o_data, o_valid, o_last, o_busy, o_done);
        end
        i_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            checks++;
            if (o_done !== 1'b0 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: done=%b valid=%b, want 0 0", o_done, o_valid);
            end
        end
        run_burst(2'd1, 10, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_burst(2'd0, 12, 2, 1'b1);
        run_burst(2'd2, 9, 0, 1'b1);
    endtask

    task automatic test_random();
        repeat (20) begin
            run_burst(2'($urandom_range(0, 3)), $urandom_range(1, 40), 2, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        run_burst(2'd0, 1, 0, 1'b0);
        run_burst(2'd3, 1, 0, 1'b0);
        run_burst(2'd1, 2, 1, 1'b0);
    endtask

    task automatic test_max_len();
        run_burst(2'd2, (1 << LW) - 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_walking_one();
        test_backpressure();
        test_prbs();
        test_zero_len();
        test_reset_mid_burst();
        test_start_while_busy();
        test_random();
        test_back_to_back();
        test_max_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
